// File: rtl/gps_pacer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gps_pacer_pkg                                                      |
// | Shared types and pio_data field positions for the GPS pacer.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gps_pacer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pacer_state_e;

  localparam int MAG_LSB    = 0;
  localparam int SIGN_BIT   = 2;
  localparam int TOGGLE_BIT = 6;
  localparam int EOS_BIT    = 7;
  localparam int SAMPLE_W   = 3;

endpackage

`default_nettype wire

// File: rtl/gps_pacer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gps_pacer_fifo                                                     |
// | Synchronous sample FIFO with flush; no write-to-read bypass.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gps_pacer_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             w_do_push, w_do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);

  // A full buffer still takes a push when a pop frees a slot on the same edge.
  assign w_do_push = push_i & (~full_o | pop_i) & ~flush_i;
  assign w_do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/gps_sample_pacer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gps_sample_pacer                                                   |
// | Buffers CPU-written GPS samples and replays them at a fixed rate.  |
// | GPS_PACER_STATS_EN: builds the emitted-sample counter.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gps_sample_pacer
  import gps_pacer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int PRIME_LEVEL  = 8,
  parameter int RATE_DIV     = 3,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [7:0]                    pio_data_i,
  output logic [SAMPLE_W-1:0]           sample_out_o,
  output logic                          sample_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          almost_full_o,
  output logic                          running_o,
  output logic                          done_o,
  output logic                          underflow_o,
  output logic                          overflow_o,
  output logic [31:0]                   sample_count_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(RATE_DIV);
  localparam logic [LW-1:0] PRIME_THR = LW'(PRIME_LEVEL);
  localparam logic [LW-1:0] AFULL_THR = LW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [CW-1:0] TICK_AT   = CW'(RATE_DIV - 1);

  pacer_state_e        state_q;
  logic                start_q;
  logic [SAMPLE_W-1:0] pio_smp_q;
  logic                pio_tog_q, pio_eos_q, tog_hist_q;
  logic [CW-1:0]       rate_cnt_q;
  logic                end_seen_q, done_q, underflow_q, overflow_q;
  logic                valid_q;
  logic [SAMPLE_W-1:0] sample_q;

  logic                w_active, w_start_rise, w_flush, w_accept;
  logic                w_push, w_eos, w_tick, w_pop, w_ovf;
  logic                w_full, w_empty;
  logic [LW-1:0]       w_level;
  logic [SAMPLE_W-1:0] w_rd_data;
  logic                w_unused_pio;

  assign w_unused_pio = ^pio_data_i[TOGGLE_BIT-1:SIGN_BIT+1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pio_smp_q  <= '0;
      pio_tog_q  <= 1'b0;
      pio_eos_q  <= 1'b0;
      tog_hist_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      pio_smp_q  <= {pio_data_i[SIGN_BIT], pio_data_i[MAG_LSB+1:MAG_LSB]};
      pio_tog_q  <= pio_data_i[TOGGLE_BIT];
      pio_eos_q  <= pio_data_i[EOS_BIT];
      tog_hist_q <= pio_tog_q;
      start_q    <= start_i;
    end
  end

  assign w_active     = (state_q == RUN) || (state_q == DRAIN);
  assign w_start_rise = start_i & ~start_q & (state_q == IDLE);
  assign w_flush      = ~start_i | w_start_rise;
  // Toggles seen while disabled or parked after completion only move the history.
  assign w_accept     = (pio_tog_q ^ tog_hist_q) & start_i & ~w_flush
                      & ~((state_q == IDLE) & done_q);
  assign w_push       = w_accept & ~pio_eos_q;
  assign w_eos        = w_accept & pio_eos_q;
  assign w_tick       = start_i & w_active & (rate_cnt_q == TICK_AT);
  assign w_pop        = w_tick & ~w_empty;
  assign w_ovf        = w_push & w_full & ~w_pop;

  gps_pacer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (w_flush),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (pio_smp_q),
    .data_o  (w_rd_data),
    .level_o (w_level),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rate_cnt_q  <= '0;
      end_seen_q  <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      sample_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (w_pop) begin
        sample_q <= w_rd_data;
        valid_q  <= 1'b1;
      end
      if (start_i && w_active) begin
        rate_cnt_q <= (rate_cnt_q == TICK_AT) ? '0 : rate_cnt_q + CW'(1);
      end else begin
        rate_cnt_q <= '0;
      end
      if (w_ovf) overflow_q <= 1'b1;
      if (w_eos) end_seen_q <= 1'b1;

      if (!start_i) begin
        state_q    <= IDLE;
        end_seen_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!start_q) begin
              state_q     <= PRIME;
              done_q      <= 1'b0;
              underflow_q <= 1'b0;
              overflow_q  <= 1'b0;
              end_seen_q  <= 1'b0;
            end
          end
          PRIME: begin
            if ((w_level >= PRIME_THR) || (end_seen_q && !w_empty)) begin
              state_q <= RUN;
            end else if (end_seen_q) begin
              state_q    <= IDLE;
              done_q     <= 1'b1;
              end_seen_q <= 1'b0;
            end
          end
          RUN: begin
            if (w_tick && w_empty) underflow_q <= 1'b1;
            if (end_seen_q) state_q <= DRAIN;
          end
          DRAIN: begin
            if (w_tick && w_empty) begin
              state_q    <= IDLE;
              done_q     <= 1'b1;
              end_seen_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef GPS_PACER_STATS_EN
  logic [31:0] sample_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_cnt_q <= '0;
    end else if (w_start_rise) begin
      sample_cnt_q <= '0;
    end else if (w_pop) begin
      sample_cnt_q <= sample_cnt_q + 32'd1;
    end
  end

  assign sample_count_o = sample_cnt_q;
`else
  assign sample_count_o = '0;
`endif

  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign fifo_level_o   = w_level;
  assign almost_full_o  = (w_level >= AFULL_THR);
  assign running_o      = w_active;
  assign done_o         = done_q;
  assign underflow_o    = underflow_q;
  assign overflow_o     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_gps_sample_pacer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gps_sample_pacer                                                |
// | Scoreboard bench: random samples in, ordered paced samples out.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_gps_sample_pacer;

  localparam int DEPTH = 16;
  localparam int PRIME = 8;
  localparam int RDIV  = 3;
  localparam int AFM   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start2;
  logic [7:0]    pio, pio2;

  logic [2:0]    so, so2;
  logic          v, v2, af, af2, run, run2, done, done2, uf, uf2, of, of2;
  logic [LW-1:0] lvl, lvl2;
  logic [31:0]   cnt, cnt2;

  always #5 clk = ~clk;

  gps_sample_pacer #(
    .FIFO_DEPTH (DEPTH), .PRIME_LEVEL (PRIME), .RATE_DIV (RDIV), .AFULL_MARGIN (AFM)
  ) u_dut (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start), .pio_data_i (pio),
    .sample_out_o (so), .sample_valid_o (v), .fifo_level_o (lvl),
    .almost_full_o (af), .running_o (run), .done_o (done),
    .underflow_o (uf), .overflow_o (of), .sample_count_o (cnt)
  );

  gps_sample_pacer #(
    .FIFO_DEPTH (DEPTH), .PRIME_LEVEL (DEPTH), .RATE_DIV (RDIV), .AFULL_MARGIN (AFM)
  ) u_ovf (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start2), .pio_data_i (pio2),
    .sample_out_o (so2), .sample_valid_o (v2), .fifo_level_o (lvl2),
    .almost_full_o (af2), .running_o (run2), .done_o (done2),
    .underflow_o (uf2), .overflow_o (of2), .sample_count_o (cnt2)
  );

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp2_q[$];
  logic tog = 1'b0, tog2 = 1'b0;
  int strobes = 0, strobes2 = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input bit eos, input int hold);
    tog = ~tog;
    pio = {eos, tog, 3'b000, s};
    if (!eos) exp_q.push_back(s);
    repeat (hold) step();
  endtask

  task automatic wr2(input logic [2:0] s, input bit eos, input bit keep);
    tog2 = ~tog2;
    pio2 = {eos, tog2, 3'b000, s};
    if (keep) exp2_q.push_back(s);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample_out"}, so, 0);
    chk({tag, "_valid"}, v, 0);
    chk({tag, "_level"}, lvl, 0);
    chk({tag, "_almost_full"}, af, 0);
    chk({tag, "_running"}, run, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_underflow"}, uf, 0);
    chk({tag, "_overflow"}, of, 0);
    chk({tag, "_count"}, cnt, 0);
  endtask

  // Monitor: in-order data and exact strobe pacing relative to run entry.
  int  cyc = 0, run_start = 0, last_strobe = 0;
  bit  prev_run = 1'b0, seen_first = 1'b0;
  always @(negedge clk) begin
    logic [2:0] e;
    cyc++;
    if (rst_n === 1'b1) begin
      if (run && !prev_run) begin
        run_start  = cyc;
        seen_first = 1'b0;
      end
      if (v) begin
        strobes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got sample %0d expected none", so);
        end else begin
          e = exp_q.pop_front();
          chk("sample_data", so, e);
        end
        chk("strobe_gap", seen_first ? cyc - last_strobe : cyc - run_start, RDIV);
        last_strobe = cyc;
        seen_first  = 1'b1;
      end
      if (v2) begin
        strobes2++;
        if (exp2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ovf_unexpected_strobe: got sample %0d expected none", so2);
        end else begin
          e = exp2_q.pop_front();
          chk("ovf_sample_data", so2, e);
        end
      end
    end
    prev_run = run;
  end

  initial begin
    int n;
    int exp_cnt;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    pio    = '0;
    pio2   = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Prime with 8 identical samples, then starve the buffer.
    start = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 8; i++) wr(3'b101, 1'b0, $urandom_range(1, 3));
    n = 0;
    while (!uf && n < 200) begin step(); n++; end
    chk("s1_underflow", uf, 1);
    chk("s1_strobes", strobes, 8);
    chk("s1_running", run, 1);
    chk("s1_queue_left", exp_q.size(), 0);

    // Short stream with end marker; sticky flags survive stop, clear on restart.
    start = 1'b0;
    repeat (2) step();
    chk("stop_underflow_held", uf, 1);
    chk("stop_running", run, 0);
    start = 1'b1;
    repeat (2) step();
    chk("restart_underflow_cleared", uf, 0);
    strobes = 0;
    for (int i = 0; i < 5; i++) wr(3'($urandom), 1'b0, $urandom_range(1, 3));
    wr(3'b000, 1'b1, 1);
    n = 0;
    while (!done && n < 200) begin step(); n++; end
    chk("s2_done", done, 1);
    chk("s2_strobes", strobes, 5);
    chk("s2_running", run, 0);
    chk("s2_level", lvl, 0);
    chk("s2_queue_left", exp_q.size(), 0);

    // Long throttled stream for the sample counter.
    start = 1'b0;
    step();
    start = 1'b1;
    repeat (2) step();
    chk("s3_done_cleared", done, 0);
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (af && n < 50) begin step(); n++; end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL s3_throttle_timeout: got almost_full 1 expected 0");
      end
      wr(3'($urandom), 1'b0, $urandom_range(1, 2));
    end
    wr(3'b000, 1'b1, 1);
    n = 0;
    while (!done && n < 2000) begin step(); n++; end
`ifdef GPS_PACER_STATS_EN
    exp_cnt = 100;
`else
    exp_cnt = 0;
`endif
    chk("s3_done", done, 1);
    chk("s3_strobes", strobes, 100);
    chk("s3_sample_count", cnt, exp_cnt);
    chk("s3_overflow", of, 0);
    chk("s3_underflow", uf, 0);
    chk("s3_queue_left", exp_q.size(), 0);

    // Reset asserted mid-RUN with five samples still buffered.
    start = 1'b0;
    step();
    start = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 12; i++) wr(3'($urandom), 1'b0, 1);
    n = 0;
    while (!(run && lvl == 5) && n < 100) begin step(); n++; end
    chk("s4_reached_level5", (run && lvl == 5), 1);
    chk("s4_almost_full_low", af, 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    exp_q.delete();
    pio   = '0;
    tog   = 1'b0;
    start = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_reset_level", lvl, 0);

    // Second instance holds playback until full: 17th write must be dropped.
    start2 = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 17; i++) wr2(3'($urandom), 1'b0, (i < DEPTH));
    step();
    chk("ovf_flag", of2, 1);
    chk("ovf_level", lvl2, DEPTH);
    chk("ovf_almost_full", af2, 1);
    wr2(3'b000, 1'b1, 1'b0);
    n = 0;
    while (!done2 && n < 300) begin step(); n++; end
    chk("ovf_done", done2, 1);
    chk("ovf_strobes", strobes2, DEPTH);
    chk("ovf_queue_left", exp2_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
